pru_buffer_scanout: RTL and testbench

//  Read-side engine for the PRU dual-port image buffer. On start, it walks the buffer linearly

---
 rtl/pru_buffer_scanout.sv | 185 ++++++++++++++++++
 tb/tb_pru_buffer_scanout.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pru_buffer_scanout.sv
// Read-side scan engine for the PRU image buffer: walks addresses 0..WIDTH*HEIGHT-1 and streams
// 2-bit pixels with sof/eol/eof sideband. Optional SCANOUT_CHECKSUM_EN adds the frame_sum port.
`timescale 1ns/1ps
module pru_buffer_scanout #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 2,
  parameter int WIDTH  = 50,
  parameter int HEIGHT = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
`ifdef SCANOUT_CHECKSUM_EN
  ,
  output logic [15:0]       frame_sum
`endif
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ENT_W = PIX_W + 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [COL_W-1:0]  col_r;

  // Read in flight: the tags issued with it, {sof, eol, eof}
  logic              infl_r;
  logic [2:0]        infl_tag_r;

  // Two-entry output FIFO; the head register drives the stream directly
  logic              head_vld_r;
  logic [ENT_W-1:0]  head_r;
  logic              tail_vld_r;
  logic [ENT_W-1:0]  tail_r;

  logic              pop_s;
  logic [1:0]        occ_s;
  logic              issue_s;
  logic [2:0]        issue_tag_s;
  logic [ENT_W-1:0]  cap_s;
  logic              fifo_idle_s;

  assign busy      = busy_r;
  assign done      = done_r;
  assign rd_addr   = rd_addr_r;
  assign pix_valid = head_vld_r;
  assign {pix_data, pix_sof, pix_eol, pix_eof} = head_r;

  // Credit check counts the slot freed by this cycle's pop so a full pipe sustains 1 pixel/cycle
  always_comb begin
    pop_s       = head_vld_r & pix_ready;
    occ_s       = {1'b0, head_vld_r} + {1'b0, tail_vld_r} + {1'b0, infl_r} - {1'b0, pop_s};
    issue_s     = (state_r == ST_RUN) && (occ_s < 2'd2);
    issue_tag_s = {(rd_addr_r == {ADDR_W{1'b0}}), (col_r == LAST_COL), (rd_addr_r == LAST_ADDR)};
    cap_s       = {rd_data, infl_tag_r};
    fifo_idle_s = !head_vld_r && !tail_vld_r && !infl_r;
  end

  // Frame sequencing, address and column counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_addr_r <= {ADDR_W{1'b0}};
      col_r     <= {COL_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r   <= ST_RUN;
            busy_r    <= 1'b1;
            rd_addr_r <= {ADDR_W{1'b0}};
            col_r     <= {COL_W{1'b0}};
          end
        end
        ST_RUN: begin
          if (issue_s) begin
            col_r <= (col_r == LAST_COL) ? {COL_W{1'b0}} : col_r + COL_W'(1'b1);
            if (rd_addr_r == LAST_ADDR) begin
              state_r <= ST_DRAIN;
            end else begin
              rd_addr_r <= rd_addr_r + ADDR_W'(1'b1);
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_idle_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Tags ride alongside the read through the buffer's one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_r     <= 1'b0;
      infl_tag_r <= 3'b000;
    end else begin
      infl_r <= issue_s;
      if (issue_s) begin
        infl_tag_r <= issue_tag_s;
      end
    end
  end

  // Output FIFO: head refills from tail first, then from the returning read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_vld_r <= 1'b0;
      head_r     <= {ENT_W{1'b0}};
      tail_vld_r <= 1'b0;
      tail_r     <= {ENT_W{1'b0}};
    end else if (!head_vld_r || pop_s) begin
      if (tail_vld_r) begin
        head_r     <= tail_r;
        head_vld_r <= 1'b1;
        tail_vld_r <= infl_r;
        if (infl_r) begin
          tail_r <= cap_s;
        end
      end else if (infl_r) begin
        head_r     <= cap_s;
        head_vld_r <= 1'b1;
      end else begin
        head_vld_r <= 1'b0;
      end
    end else if (infl_r) begin
      tail_r     <= cap_s;
      tail_vld_r <= 1'b1;
    end
  end

`ifdef SCANOUT_CHECKSUM_EN
  logic [15:0] sum_r;
  assign frame_sum = sum_r;

  // Running sum of accepted pixels, restarted by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= 16'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      sum_r <= 16'd0;
    end else if (pop_s) begin
      sum_r <= sum_r + {{(16-PIX_W){1'b0}}, head_r[ENT_W-1:3]};
    end
  end
`endif

endmodule

// File: tb/tb_pru_buffer_scanout.sv
// Scoreboard bench for pru_buffer_scanout: expected pixels are queued at start and popped on handshake.
`timescale 1ns/1ps
module tb_pru_buffer_scanout;

  localparam int ADDR_W = 19;
  localparam int PIX_W  = 2;
  localparam int WIDTH  = 50;
  localparam int HEIGHT = 50;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              pix_ready = 1'b0;
  logic              busy, done, pix_valid, pix_sof, pix_eol, pix_eof;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data, pix_data;

  logic              start1 = 1'b0;
  logic              pix_ready1 = 1'b1;
  logic              busy1, done1, pix_valid1, sof1, eol1, eof1;
  logic [ADDR_W-1:0] rd_addr1;
  logic [PIX_W-1:0]  rd_data1, pix_data1;
`ifdef SCANOUT_CHECKSUM_EN
  logic [15:0]       frame_sum, frame_sum1;
`endif

  logic [PIX_W-1:0]  mem [NPIX];
  logic [4:0]        exp_q [$];
  logic [4:0]        mon_e;
  logic [4:0]        hold_val;
  logic              hold_r = 1'b0;
  int                n_cmp = 0;
  int                n_err = 0;
  int                n_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  pru_buffer_scanout #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
`ifdef SCANOUT_CHECKSUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  pru_buffer_scanout #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .WIDTH(1), .HEIGHT(1)) dut_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .pix_data(pix_data1), .pix_valid(pix_valid1),
    .pix_ready(pix_ready1), .pix_sof(sof1), .pix_eol(eol1), .pix_eof(eof1)
`ifdef SCANOUT_CHECKSUM_EN
    , .frame_sum(frame_sum1)
`endif
  );

  always #5 clk = ~clk;

  // Buffer models: registered read, one cycle latency
  always @(posedge clk) rd_data <= mem[rd_addr];
  always @(posedge clk) rd_data1 <= (rd_addr1 == {ADDR_W{1'b0}}) ? 2'b10 : 2'b00;

  // Stream monitor: hold stability and in-order scoreboard compare
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_r = 1'b0;
    end else begin
      if (hold_r) begin
        chk("hold_valid", pix_valid, 1'b1);
        chk("hold_stable", {pix_data, pix_sof, pix_eol, pix_eof}, hold_val);
      end
      if (pix_valid && pix_ready) begin
        chk("queue_has_entry", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("pix", {pix_data, pix_sof, pix_eol, pix_eof}, mon_e);
        end
        n_acc++;
      end
      hold_r   = pix_valid && !pix_ready;
      hold_val = {pix_data, pix_sof, pix_eol, pix_eof};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back({mem[i], (i == 0), ((i % WIDTH) == WIDTH - 1), (i == NPIX - 1)});
    end
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, input bit rnd, output int cyc);
    bit fin;
    fin = 1'b0;
    cyc = c0;
    while (!fin) begin
      tick();
      cyc++;
      if (rnd) pix_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (done === 1'b1) begin
        fin = 1'b1;
      end else if (cyc >= 12000) begin
        chk("done_timeout", done, 1'b1);
        fin = 1'b1;
      end
    end
    pix_ready = 1'b1;
  endtask

  task automatic wait_acc(input int target);
    int guard;
    guard = 0;
    while (n_acc < target && guard < 6000) begin
      tick();
      guard++;
    end
    chk("acc_reached", (n_acc >= target), 1'b1);
  endtask

  task automatic check_reset_outs();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_addr", rd_addr, 19'd0);
    chk("rst_valid", pix_valid, 1'b0);
    chk("rst_data", pix_data, 2'd0);
    chk("rst_tags", {pix_sof, pix_eol, pix_eof}, 3'd0);
  endtask

  initial begin
    int cyc;
    int base;

    // Reset state and quiet idle
    #3;
    check_reset_outs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk("idle_valid", pix_valid, 1'b0);
    end

    // Linear addr%4 frame at full rate: latency, tags, done timing
    for (int i = 0; i < NPIX; i++) mem[i] = 2'(i % 4);
    pix_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("first_rd_addr", rd_addr, 19'd0);
    chk("busy_after_start", busy, 1'b1);
    chk("valid_cyc0", pix_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("valid_cyc1", pix_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("valid_cyc2", pix_valid, 1'b1);
    wait_done(2, 1'b0, cyc);
    chk("done_cycle", cyc, NPIX + 3);
    chk("busy_at_done", busy, 1'b0);
    chk("rd_addr_hold", rd_addr, 19'(NPIX - 1));
    chk("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);

    // Random data under random backpressure
    for (int i = 0; i < NPIX; i++) mem[i] = 2'($urandom);
    base = n_acc;
    pulse_start();
    wait_done(0, 1'b1, cyc);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_count", n_acc - base, NPIX);

    // Twenty-cycle stall with pixel 137 at the head
    for (int i = 0; i < NPIX; i++) mem[i] = 2'(i % 4);
    base = n_acc;
    pulse_start();
    wait_acc(base + 137);
    pix_ready = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("stall_rd_addr", rd_addr, 19'd139);
    end
    tick();
    pix_ready = 1'b1;
    wait_done(0, 1'b0, cyc);
    chk("stall_queue_empty", exp_q.size(), 0);
    chk("stall_count", n_acc - base, NPIX);

    // Start while busy is ignored; reset mid-frame clears everything
    base = n_acc;
    pulse_start();
    wait_acc(base + 1000);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_ignored_start", busy, 1'b1);
    wait_acc(base + 1200);
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_done", done, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end
    pulse_start();
    wait_done(0, 1'b0, cyc);
    chk("rescan_done_cycle", cyc, NPIX + 3);
    chk("rescan_queue_empty", exp_q.size(), 0);

`ifdef SCANOUT_CHECKSUM_EN
    // Checksum over an all-3 frame, then an all-0 frame
    for (int i = 0; i < NPIX; i++) mem[i] = 2'd3;
    pulse_start();
    wait_done(0, 1'b0, cyc);
    chk("sum_all3", frame_sum, 16'h1D4C);
    @(negedge clk);
    chk("sum_stable", frame_sum, 16'h1D4C);
    for (int i = 0; i < NPIX; i++) mem[i] = 2'd0;
    pulse_start();
    wait_done(0, 1'b0, cyc);
    chk("sum_all0", frame_sum, 16'h0000);
`endif

    // Single-pixel frame: sof, eol and eof together; done at start+4
    tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk("one_pixel", {pix_valid1, pix_data1, sof1, eol1, eof1}, 6'b110111);
      end
      chk("one_done", done1, (c == 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
